// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Optional CRC checking is enabled by defining CCFF_LOADER_CRC_EN.
package ccff_loader_pkg;

    // Loader FSM states; CHECK exists only when CRC checking is built in.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
`ifdef CCFF_LOADER_CRC_EN
        ST_CHECK = 2'd2,
`endif
        ST_FIN   = 2'd3
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/ccff_crc8.sv
// Bit-serial CRC-8 (MSB first) over the bits fed into the configuration chain.
module ccff_crc8
    import ccff_loader_pkg::*;
(
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_i,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Next CRC value: restart on clr, otherwise fold in one bit when enabled
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC8_INIT;
        end else if (en) begin
            crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ bit_i) ? CRC8_POLY : 8'h00);
        end
    end

    // CRC register
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: double-buffered word input, serial MSB-first
// shift into the chain head for exactly CHAIN_LEN enabled cycles.
// Define CCFF_LOADER_CRC_EN to add a trailing CRC-8 check word (CHECK state).
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int BITS_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BITS_W-1:0] WORD_BITS = BITS_W'(WORD_W);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic                hold_v_q, hold_v_d;
    logic [WORD_W-1:0]   shr_q, shr_d;
    logic                shr_v_q, shr_v_d;
    logic [BITS_W-1:0]   shr_bits_q, shr_bits_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                ready_raw;
    logic                in_xfer;
    logic                shift;
    logic                last_shift;
    logic [WORD_W-1:0]   src_word;
    logic [BITS_W-1:0]   src_bits;

`ifdef CCFF_LOADER_CRC_EN
    logic                err_q, err_d;
    logic [7:0]          crc;
`endif

    // Datapath and FSM next-state. The shift source is the shift register when
    // it holds bits, else the holding register directly, so a word moving from
    // holding to shift register never costs an idle chain cycle.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        shr_d      = shr_q;
        shr_v_d    = shr_v_q;
        shr_bits_d = shr_bits_q;
        cnt_d      = cnt_q;
`ifdef CCFF_LOADER_CRC_EN
        err_d      = err_q;
        ready_raw  = ((state_q == ST_LOAD) || (state_q == ST_CHECK)) && !hold_v_q;
`else
        ready_raw  = (state_q == ST_LOAD) && !hold_v_q;
`endif
        in_xfer    = din_valid && ready_raw;
        src_word   = shr_v_q ? shr_q : hold_q;
        src_bits   = shr_v_q ? shr_bits_q : WORD_BITS;
        shift      = (state_q == ST_LOAD) && (shr_v_q || hold_v_q);
        last_shift = shift && (cnt_q == LAST_BIT);

        if (shift) begin
            cnt_d      = cnt_q + 1'b1;
            shr_d      = src_word << 1;
            shr_bits_d = src_bits - 1'b1;
            // Leftover low bits of the final word are dropped here.
            shr_v_d    = (src_bits != BITS_W'(1)) && !last_shift;
            if (!shr_v_q) begin
                hold_v_d = 1'b0;
            end
        end

        if (in_xfer) begin
            hold_d   = din;
            hold_v_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    cnt_d    = '0;
                    hold_v_d = 1'b0;
                    shr_v_d  = 1'b0;
`ifdef CCFF_LOADER_CRC_EN
                    err_d    = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (last_shift) begin
`ifdef CCFF_LOADER_CRC_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_FIN;
`endif
                end
            end
`ifdef CCFF_LOADER_CRC_EN
            ST_CHECK: begin
                if (hold_v_q) begin
                    state_d  = ST_FIN;
                    hold_v_d = 1'b0;
                    err_d    = err_q | (hold_q[7:0] != crc);
                end
            end
`endif
            ST_FIN: begin
                state_d  = ST_IDLE;
                hold_v_d = 1'b0;
                shr_v_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and buffer registers
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            shr_q      <= '0;
            shr_v_q    <= 1'b0;
            shr_bits_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_v_q   <= hold_v_d;
            shr_q      <= shr_d;
            shr_v_q    <= shr_v_d;
            shr_bits_q <= shr_bits_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef CCFF_LOADER_CRC_EN
    // Sticky CRC mismatch flag
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    ccff_crc8 u_crc (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clr      ((state_q == ST_IDLE) && start),
        .en       (shift),
        .bit_i    (src_word[WORD_W-1]),
        .crc      (crc)
    );

    assign err = err_q & ~pReset;
`else
    assign err = 1'b0;
`endif

    // Outputs are forced low while reset is asserted so the chain never moves then.
    assign din_ready   = ready_raw & ~pReset;
    assign ccff_clk_en = shift & ~pReset;
    assign ccff_head   = shift & src_word[WORD_W-1] & ~pReset;
    assign busy        = (state_q != ST_IDLE) & ~pReset;
    assign done        = (state_q == ST_FIN) & ~pReset;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: three instances (CHAIN_LEN 16, 12, 8), a per-cycle
// stream/timing model, directed cases plus randomized loads.
module tb_ccff_loader;

    localparam int NI = 3;
`ifdef CCFF_LOADER_CRC_EN
    localparam bit CRC = 1'b1;
`else
    localparam bit CRC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_s   [NI];
    logic       start_s [NI];
    logic [7:0] din_s   [NI];
    logic       dv_s    [NI];
    logic       rdy     [NI];
    logic       head    [NI];
    logic       cken    [NI];
    logic       bsy     [NI];
    logic       dn      [NI];
    logic       er      [NI];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model state
    bit          m_busy     [NI];
    int          m_need     [NI];
    logic [31:0] m_stream   [NI];
    int          m_wr       [NI];
    int          m_rd       [NI];
    int          m_last     [NI];
    int          m_crcc     [NI];
    int          m_done_at  [NI];
    bit          m_err      [NI];
    bit          m_err_next [NI];
    logic [31:0] cap        [NI];
    logic [31:0] last_cap   [NI];
    int          shifts     [NI];
    int          last_shifts[NI];
    int          done_cnt   [NI];
    logic        last_err   [NI];
    logic [7:0]  wbuf       [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 16 : (g == 1) ? 12 : 8;
        ccff_loader #(.CHAIN_LEN(L), .WORD_W(8)) u_dut (
            .prog_clk    (clk),
            .pReset      (rst_s[g]),
            .start       (start_s[g]),
            .din         (din_s[g]),
            .din_valid   (dv_s[g]),
            .din_ready   (rdy[g]),
            .ccff_head   (head[g]),
            .ccff_clk_en (cken[g]),
            .busy        (bsy[g]),
            .done        (dn[g]),
            .err         (er[g])
        );
    end

    function automatic int len_of(int k);
        return (k == 0) ? 16 : (k == 1) ? 12 : 8;
    endfunction

    // CRC as remainder of (message * x^8) divided by x^8+x^2+x+1
    function automatic logic [7:0] crc_of(logic [31:0] s, int n);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < n + 8; i++) begin
            r = {r[7:0], (i < n) ? s[i] : 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle compare against the stream model
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < NI; k++) begin
            bit was_busy;
            bit is_done;
            int pend;
            int n;
            if (rst_s[k]) begin
                m_busy[k] = 0; m_wr[k] = 0; m_rd[k] = 0; m_need[k] = 0;
                m_err[k] = 0; m_err_next[k] = 0; m_last[k] = -1; m_crcc[k] = -1;
                m_done_at[k] = -1; shifts[k] = 0; cap[k] = '0; m_stream[k] = '0;
            end else begin
                was_busy = m_busy[k];
                is_done  = was_busy && (cyc == m_done_at[k]);
                if (is_done) m_err[k] = m_err_next[k];
                check("busy", bsy[k], was_busy);
                check("done", dn[k], is_done);
                check("err", er[k], m_err[k]);
                pend = m_wr[k] - m_rd[k];
                check("clk_en", cken[k], was_busy && (pend > 0));
                if (cken[k] && pend > 0) begin
                    check("head", head[k], m_stream[k][m_rd[k]]);
                    m_rd[k]++;
                    shifts[k]++;
                    cap[k] = {cap[k][30:0], head[k]};
                    if (m_rd[k] == len_of(k)) begin
                        m_last[k] = cyc;
                        if (!CRC) m_done_at[k] = cyc + 1;
                        else if (m_crcc[k] >= 0)
                            m_done_at[k] = ((cyc > m_crcc[k]) ? cyc : m_crcc[k]) + 2;
                    end
                end else begin
                    check("head_idle", head[k], 1'b0);
                end
                if (!was_busy || is_done) check("ready_off", rdy[k], 1'b0);
                if (is_done) begin
                    check("shift_total", shifts[k], len_of(k));
                    last_cap[k]    = cap[k];
                    last_shifts[k] = shifts[k];
                    last_err[k]    = er[k];
                    m_busy[k]      = 0;
                end
                if (dn[k]) done_cnt[k]++;
                if (dv_s[k] && rdy[k] && was_busy && !is_done) begin
                    if (m_need[k] > 0) begin
                        n = (m_need[k] < 8) ? m_need[k] : 8;
                        for (int j = 0; j < n; j++) m_stream[k][m_wr[k] + j] = din_s[k][7 - j];
                        m_wr[k]   += n;
                        m_need[k] -= n;
                    end else if (CRC) begin
                        m_crcc[k]     = cyc;
                        m_err_next[k] = (din_s[k] != crc_of(m_stream[k], len_of(k)));
                        if (m_last[k] >= 0)
                            m_done_at[k] = ((m_last[k] > cyc) ? m_last[k] : cyc) + 2;
                    end
                end
                if (start_s[k] && !was_busy) begin
                    m_busy[k] = 1; m_need[k] = len_of(k); m_wr[k] = 0; m_rd[k] = 0;
                    shifts[k] = 0; cap[k] = '0; m_err[k] = 0; m_err_next[k] = 0;
                    m_last[k] = -1; m_crcc[k] = -1; m_done_at[k] = -1; m_stream[k] = '0;
                end
            end
        end
    end

    task automatic pulse_start(int k);
        start_s[k] = 1'b1;
        @(posedge clk); #1;
        start_s[k] = 1'b0;
    endtask

    task automatic push_word(int k, logic [7:0] w, int gap);
        int n;
        n = 0;
        din_s[k] = w;
        dv_s[k]  = 1'b1;
        @(negedge clk);
        while (!rdy[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("push_timeout", rdy[k], 1'b1);
        @(posedge clk); #1;
        dv_s[k]  = 1'b0;
        din_s[k] = 8'($urandom);
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(int k);
        int d0;
        int n;
        d0 = done_cnt[k];
        n  = 0;
        while (done_cnt[k] == d0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("done_timeout", done_cnt[k] - d0, 1);
        #1;
    endtask

    // Full load from wbuf; with CRC built in, a trailing check word follows
    task automatic run_load(int k, int gap, bit crc_bad);
        int          nw;
        int          p;
        logic [31:0] s;
        logic [7:0]  w;
        nw = (len_of(k) + 7) / 8;
        p  = 0;
        s  = '0;
        pulse_start(k);
        for (int i = 0; i < nw; i++) begin
            w = wbuf[i];
            push_word(k, w, gap);
            for (int j = 0; j < 8; j++) begin
                if (p < len_of(k)) begin
                    s[p] = w[7 - j];
                    p++;
                end
            end
        end
        if (CRC) push_word(k, crc_of(s, len_of(k)) ^ (crc_bad ? 8'h0F : 8'h00), gap);
        wait_done(k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < NI; k++) begin
            rst_s[k] = 1'b1; start_s[k] = 1'b0; din_s[k] = 8'h00; dv_s[k] = 1'b0;
            done_cnt[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rst_s[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("rst_ready", rdy[k], 1'b0);
            check("rst_head", head[k], 1'b0);
            check("rst_clk_en", cken[k], 1'b0);
            check("rst_busy", bsy[k], 1'b0);
            check("rst_done", dn[k], 1'b0);
            check("rst_err", er[k], 1'b0);
        end
        @(posedge clk); #1;

        check("crc_model_pin", crc_of(32'h80, 8), 8'h07);

        // 0xA5, 0x3C back-to-back on 16-bit chain
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C; wbuf[2] = 8'h00; wbuf[3] = 8'h00;
        run_load(0, 0, 1'b0);
        check("a53c_bits", last_cap[0][15:0], 16'hA53C);
        check("a53c_shifts", last_shifts[0], 16);

        // partial last word on 12-bit chain
        wbuf[0] = 8'hF0; wbuf[1] = 8'h9F;
        run_load(1, 0, 1'b0);
        check("partial_bits", last_cap[1][11:0], 12'hF09);
        check("partial_shifts", last_shifts[1], 12);

        // 5-cycle gaps between words
        wbuf[0] = 8'h6E; wbuf[1] = 8'hB1;
        run_load(0, 5, 1'b0);
        check("gap_bits", last_cap[0][15:0], 16'h6EB1);
        check("gap_err", er[0], 1'b0);

        // reset after 7 shifts, then a fresh full load
        pulse_start(0);
        push_word(0, 8'hA5, 0);
        push_word(0, 8'h3C, 0);
        n = 0;
        while (shifts[0] < 7 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("reach_7_shifts", shifts[0] >= 7, 1'b1);
        #1;
        rst_s[0] = 1'b1;
        @(posedge clk); #1;
        rst_s[0] = 1'b0;
        @(negedge clk);
        check("midrst_ready", rdy[0], 1'b0);
        check("midrst_head", head[0], 1'b0);
        check("midrst_clk_en", cken[0], 1'b0);
        check("midrst_busy", bsy[0], 1'b0);
        check("midrst_done", dn[0], 1'b0);
        check("midrst_err", er[0], 1'b0);
        @(posedge clk); #1;
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        run_load(0, 0, 1'b0);
        check("postrst_bits", last_cap[0][15:0], 16'hA53C);

        // din_valid held in IDLE, start pulsed mid-load
        din_s[1] = 8'h77; dv_s[1] = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_ready", rdy[1], 1'b0);
        check("idle_busy", bsy[1], 1'b0);
        @(posedge clk); #1;
        dv_s[1] = 1'b0;
        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
        fork
            run_load(1, 1, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1;
                start_s[1] = 1'b1;
                @(posedge clk); #1;
                start_s[1] = 1'b0;
            end
        join
        check("restart_ignored_bits", last_cap[1][11:0], 12'h5AC);

`ifdef CCFF_LOADER_CRC_EN
        // CRC word 0x07 matches, 0x08 does not
        wbuf[0] = 8'h01;
        run_load(2, 0, 1'b0);
        check("crc_good_err", last_err[2], 1'b0);
        run_load(2, 0, 1'b1);
        check("crc_bad_err", last_err[2], 1'b1);
`endif

        // randomized loads
        for (int it = 0; it < 24; it++) begin
            int k;
            k = $urandom_range(0, 2);
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            run_load(k, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 1024, giving the configuration-chain length in bits (range 1..65535).
REQ-002 The block SHALL have parameter WORD_W, default 8, giving the bitstream word width in bits.
REQ-003 The block SHALL have port prog_clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port pReset, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, width 1: a one-cycle pulse that begins a load.
REQ-006 The block SHALL have port din, input, width WORD_W: bitstream word, loaded MSB first.
REQ-007 The block SHALL have port din_valid, input, width 1: din is valid.
REQ-008 The block SHALL have port din_ready, output, width 1: block accepts din this cycle.
REQ-009 The block SHALL have port ccff_head, output, width 1: serial bit driven into the chain head.
REQ-010 The block SHALL have port ccff_clk_en, output, width 1: chain shift enable; the chain advances on this cycle's edge.
REQ-011 The block SHALL have port busy, output, width 1: a load is in progress.
REQ-012 The block SHALL have port done, output, width 1: one-cycle pulse when a load completes.
REQ-013 The block SHALL have port err, output, width 1: sticky error flag, cleared by start.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, CHECK and FIN.
REQ-015 IDLE: start SHALL move the FSM to LOAD, clear err and zero the bit counter; otherwise it SHALL hold.
REQ-016 Double buffering: the block SHALL hold one holding register and one shift register, each with a valid flag.
REQ-017 din_ready SHALL equal (state==LOAD or state==CHECK) and holding register empty.
REQ-018 Transfer SHALL occur when din_valid and din_ready are both high in the same cycle.
REQ-019 When the shift register is empty and the holding register is full, the word SHALL move to the shift register in the same cycle as a shift, so there is no bubble.
REQ-020 LOAD: in each cycle with the shift register valid, ccff_clk_en SHALL be 1, ccff_head SHALL be the current MSB, the shift register SHALL shift left, and the bit counter SHALL increment.
REQ-021 No data available in LOAD (underflow) SHALL give ccff_clk_en=0 and ccff_head=0, with the chain held; this is a stall and not an error.
REQ-022 Partial last word: when CHAIN_LEN mod WORD_W != 0, only the remaining MSBs of the last word SHALL be shifted and its low bits discarded.
REQ-023 Exactly CHAIN_LEN cycles with ccff_clk_en=1 SHALL occur per load.
REQ-024 After the bit counter reaches CHAIN_LEN, the FSM SHALL go to CHECK if the feature in REQ-034 is compiled in, otherwise to FIN.
REQ-025 FIN SHALL pulse done for one cycle, then return to IDLE; busy SHALL be 1 in LOAD, CHECK and FIN.
REQ-026 start asserted while busy SHALL be ignored.
REQ-027 A din_valid word offered outside LOAD/CHECK SHALL not be consumed.
REQ-028 The bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never wrap.
REQ-029 Latency: the first ccff_clk_en SHALL occur one cycle after the first accepted word.

Reset
REQ-030 pReset SHALL take effect at any cycle, including mid-load, and override start.
REQ-031 On pReset, state SHALL go to IDLE and the buffers SHALL become empty.
REQ-032 On pReset, the counter SHALL be 0.
REQ-033 On pReset, din_ready, ccff_head, ccff_clk_en, busy, done and err SHALL all be 0.

Configuration
REQ-034 With macro CCFF_LOADER_CRC_EN defined, the block SHALL compute CRC-8 (polynomial 0x07, init 0x00, MSB first) over the bits actually shifted.
REQ-035 With CCFF_LOADER_CRC_EN, CHECK SHALL accept one further word (low 8 bits) as the expected CRC with ccff_clk_en=0, SHALL set err on mismatch, then go to FIN.
REQ-036 Without CCFF_LOADER_CRC_EN, the design SHALL have no CHECK state and no CRC logic, and err SHALL be constant 0.

Structure
REQ-037 Package ccff_loader_pkg SHALL contain the state enum, CRC8_POLY=8'h07 and CRC8_INIT=8'h00.
REQ-038 Sub-module ccff_crc8 SHALL implement a bit-serial CRC update (inputs prog_clk, pReset, clr, en, bit; output crc[7:0]), instantiated only under CCFF_LOADER_CRC_EN.

Verification
REQ-039 CHAIN_LEN=16: start, then words 0xA5 and 0x3C back-to-back -> ccff_head 1010010100111100 over 16 consecutive ccff_clk_en cycles, then done one cycle later.
REQ-040 CHAIN_LEN=12: word 0xF0 followed by word 0x9F -> 12 shifts, bits 11110000 1001 in order, low nibble of 0x9F discarded.
REQ-041 With din_valid gaps of 5 cycles between words -> ccff_clk_en=0 during the gaps, total shifts still equal CHAIN_LEN, and err=0.
REQ-042 pReset asserted after 7 of 16 shifts -> next cycle all outputs are 0 and state is IDLE; a fresh start then loads all 16 bits.
REQ-043 CRC_EN, CHAIN_LEN=8: word 0x01 then CRC word 0x07 -> err=0; repeating with CRC word 0x08 -> err=1, and done still pulses.
REQ-044 start pulsed mid-load and din_valid held in IDLE -> no restart and no word consumed.
